// File: rtl/multiword_add_sequencer_if.sv
// Request/result handshake bundle for multiword_add_sequencer.
// Defining MULTIWORD_ADD_OVF_EN adds the signed-overflow flag to the bundle.
interface multiword_add_sequencer_if #(
    parameter int N     = 32,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
`ifdef MULTIWORD_ADD_OVF_EN
    logic         ovf;

    modport master (
        output in_valid, op_a, op_b, op_sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, busy, ovf
    );
    modport slave (
        input  in_valid, op_a, op_b, op_sub, cin, out_ready,
        output in_ready, out_valid, result, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, op_a, op_b, op_sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, busy
    );
    modport slave (
        input  in_valid, op_a, op_b, op_sub, cin, out_ready,
        output in_ready, out_valid, result, cout, busy
    );
`endif
endinterface

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built from one N-bit carry-select adder, one word per cycle, LSW first.
// Optional signed-overflow output is enabled with the macro MULTIWORD_ADD_OVF_EN.
module multiword_add_sequencer #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multiword_add_sequencer_if.slave bus
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               out_valid_q, out_valid_d;
`ifdef MULTIWORD_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               clear_result;
    logic               word_we;
    logic               last_word;

    logic [N-1:0]       add_a;
    logic [N-1:0]       add_b;
    logic               add_ci;
    logic [N-1:0]       add_sum;
    logic               add_co;

    logic [N-1:0]       a_word [WORDS];
    logic [N-1:0]       b_word [WORDS];

    // Operand word split and per-word result write-back.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign a_word[gi] = a_q[gi*N +: N];
            assign b_word[gi] = b_q[gi*N +: N];
            assign result_d[gi*N +: N] =
                clear_result                            ? '0      :
                (word_we && (idx_q == IDX_W'(gi)))      ? add_sum :
                                                          result_q[gi*N +: N];
        end
    endgenerate

    assign add_a     = a_word[idx_q];
    assign add_b     = b_word[idx_q];
    assign add_ci    = carry_q;
    assign last_word = (idx_q == IDX_W'(WORDS - 1));

    // Carry-select word adder: low half ripples, upper half is precomputed for both carries.
    generate
        if (N == 1) begin : g_add_bit
            logic [1:0] sum2;
            assign sum2    = {1'b0, add_a} + {1'b0, add_b} + {1'b0, add_ci};
            assign add_sum = sum2[0];
            assign add_co  = sum2[1];
        end else begin : g_add_csel
            localparam int LO_W = N / 2;
            localparam int HI_W = N - LO_W;
            logic [LO_W:0] lo;
            logic [HI_W:0] hi0;
            logic [HI_W:0] hi1;
            assign lo  = {1'b0, add_a[LO_W-1:0]} + {1'b0, add_b[LO_W-1:0]}
                       + {{LO_W{1'b0}}, add_ci};
            assign hi0 = {1'b0, add_a[N-1:LO_W]} + {1'b0, add_b[N-1:LO_W]};
            assign hi1 = {1'b0, add_a[N-1:LO_W]} + {1'b0, add_b[N-1:LO_W]}
                       + {{HI_W{1'b0}}, 1'b1};
            assign add_sum = {(lo[LO_W] ? hi1[HI_W-1:0] : hi0[HI_W-1:0]), lo[LO_W-1:0]};
            assign add_co  = lo[LO_W] ? hi1[HI_W] : hi0[HI_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_word)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        cout_d       = cout_q;
        out_valid_d  = out_valid_q;
        clear_result = 1'b0;
        word_we      = 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtract is folded into A + ~B + 1 so RUN never needs to know the op.
                    a_d          = bus.op_a;
                    b_d          = bus.op_sub ? ~bus.op_b : bus.op_b;
                    carry_d      = bus.op_sub ? 1'b1 : bus.cin;
                    idx_d        = '0;
                    clear_result = 1'b1;
                end
            end
            RUN: begin
                word_we = 1'b1;
                carry_d = add_co;
                if (last_word) begin
                    cout_d      = add_co;
                    out_valid_d = 1'b1;
`ifdef MULTIWORD_ADD_OVF_EN
                    ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = out_valid_q;
        bus.result    = result_q;
        bus.cout      = cout_q;
`ifdef MULTIWORD_ADD_OVF_EN
        bus.ovf       = ovf_q;
`endif
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed, table-driven bench for multiword_add_sequencer (N=32, WORDS=4).
// Overflow checks are included when MULTIWORD_ADD_OVF_EN is defined.
module tb_multiword_add_sequencer;
    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiword_add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();
    multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         ci;
        logic [W-1:0] exp_res;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [8];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid after an accept edge; returns edge count (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.out_valid && lat < 20);
    endtask

    task automatic run_vec(input int i);
        int lat;
        chk("in_ready_before_accept", W'(bus.in_ready), W'(1));
        bus.op_a = vecs[i].a; bus.op_b = vecs[i].b;
        bus.op_sub = vecs[i].sub; bus.cin = vecs[i].ci;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.op_sub = 1'b0; bus.cin = 1'b0;
        wait_valid(lat);
        chk("latency", W'(lat), W'(WORDS));
        chk("result", bus.result, vecs[i].exp_res);
        chk("cout", W'(bus.cout), W'(vecs[i].exp_cout));
`ifdef MULTIWORD_ADD_OVF_EN
        chk("ovf", W'(bus.ovf), W'(vecs[i].exp_ovf));
`endif
        $display("vec %0d: a=%h b=%h sub=%0d -> result=%h cout=%0d lat=%0d",
                 i, vecs[i].a, vecs[i].b, vecs[i].sub, bus.result, bus.cout, lat);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid_after_handshake", W'(bus.out_valid), W'(0));
        chk("in_ready_after_handshake", W'(bus.in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] maxpos;
        logic [W-1:0] minneg;
        int lat;
        bit seen;
        ones   = '1;
        maxpos = {1'b0, {(W-1){1'b1}}};
        minneg = {1'b1, {(W-1){1'b0}}};

        vecs[0] = '{128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
                    128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0};
        vecs[1] = '{ones, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0};
        vecs[2] = '{'0, 128'h1, 1'b1, 1'b1, ones, 1'b0, 1'b0};
        vecs[3] = '{128'h5, 128'h5, 1'b1, 1'b0, '0, 1'b1, 1'b0};
        vecs[4] = '{maxpos, 128'h1, 1'b0, 1'b0, minneg, 1'b0, 1'b1};
        vecs[5] = '{minneg, 128'h1, 1'b1, 1'b0, maxpos, 1'b1, 1'b1};
        vecs[6] = '{128'h5, 128'h3, 1'b0, 1'b0, 128'h8, 1'b0, 1'b0};
        vecs[7] = '{ones, ones, 1'b0, 1'b1, ones, 1'b1, 1'b0};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.op_sub = 1'b0; bus.cin = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset_in_ready", W'(bus.in_ready), W'(1));
        chk("reset_busy", W'(bus.busy), W'(0));
        chk("reset_out_valid", W'(bus.out_valid), W'(0));
        chk("reset_result", bus.result, '0);
        chk("reset_cout", W'(bus.cout), W'(0));

        for (int i = 0; i < 8; i++) run_vec(i);

        // Backpressure: result held, new request refused while DONE.
        bus.op_a = vecs[0].a; bus.op_b = vecs[0].b; bus.op_sub = 1'b0; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_latency", W'(lat), W'(WORDS));
        bus.op_a = vecs[6].a; bus.op_b = vecs[6].b; bus.op_sub = 1'b0; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_out_valid", W'(bus.out_valid), W'(1));
            chk("bp_result", bus.result, vecs[0].exp_res);
            chk("bp_cout", W'(bus.cout), W'(vecs[0].exp_cout));
            chk("bp_in_ready", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release_idle", W'(bus.in_ready), W'(1));
        chk("bp_release_out_valid", W'(bus.out_valid), W'(0));
        tick();
        bus.in_valid = 1'b0;
        chk("bp_pending_accepted", W'(bus.busy), W'(1));
        wait_valid(lat);
        chk("bp_pending_latency", W'(lat), W'(WORDS));
        chk("bp_pending_result", bus.result, vecs[6].exp_res);
        $display("backpressure: pending result=%h lat=%0d", bus.result, lat);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset while idx=2: operation abandoned.
        bus.op_a = vecs[7].a; bus.op_b = vecs[7].b; bus.op_sub = 1'b0; bus.cin = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("midrun_partial_result", bus.result, {64'h0, 64'hFFFFFFFF_FFFFFFFF});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready", W'(bus.in_ready), W'(1));
        chk("abort_busy", W'(bus.busy), W'(0));
        chk("abort_out_valid", W'(bus.out_valid), W'(0));
        chk("abort_result", bus.result, '0);
        chk("abort_cout", W'(bus.cout), W'(0));
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_result", W'(seen), W'(0));
        $display("abort: out_valid seen=%0d", seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
